// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller beside the ID/EX register of a 5-stage core.
// Latency: selects and ex_bubble are registered and align with the instruction in EX; stall is combinational.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and a bubble enters EX; flush overrides stall.
// Optional: define HAZARD_STATS_EN to add saturating stall_cnt / fwd_cnt outputs.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             stall,
`ifdef HAZARD_STATS_EN
    output logic [15:0]      stall_cnt,
    output logic [15:0]      fwd_cnt,
`endif
    output logic             ex_bubble
);

    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // The WB slot needs no storage here: its result reaches ID through the register file.
    logic [REG_W-1:0] ex_dest;
    logic             ex_wr;
    logic             ex_ld;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wr;

    logic             ex_hit_rs;
    logic             ex_hit_rt;
    logic             mem_hit_rs;
    logic             mem_hit_rt;
    logic             id_enter;
    logic [SEL_W-1:0] a_sel_nxt;
    logic [SEL_W-1:0] b_sel_nxt;

    always_comb begin
        ex_hit_rs  = ex_wr  && (ex_dest  != REG_ZERO) && id_use_rs && (id_rs == ex_dest);
        ex_hit_rt  = ex_wr  && (ex_dest  != REG_ZERO) && id_use_rt && (id_rt == ex_dest);
        mem_hit_rs = mem_wr && (mem_dest != REG_ZERO) && id_use_rs && (id_rs == mem_dest);
        mem_hit_rt = mem_wr && (mem_dest != REG_ZERO) && id_use_rt && (id_rt == mem_dest);
    end

    // A load still in EX cannot feed the next instruction; flush squashes the consumer anyway.
    always_comb begin
        stall = id_valid && !flush && ex_ld && (ex_hit_rs || ex_hit_rt);
    end

    assign id_enter = id_valid && !stall && !flush;

    always_comb begin
        a_sel_nxt = SEL_RF;
        b_sel_nxt = SEL_RF;
        if (id_enter) begin
            if (ex_hit_rs)       a_sel_nxt = SEL_MEM;
            else if (mem_hit_rs) a_sel_nxt = SEL_WB;
            if (ex_hit_rt)       b_sel_nxt = SEL_MEM;
            else if (mem_hit_rt) b_sel_nxt = SEL_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dest   <= '0;
            ex_wr     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_dest  <= '0;
            mem_wr    <= 1'b0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
            ex_bubble <= 1'b1;
        end else begin
            mem_dest  <= ex_dest;
            mem_wr    <= ex_wr;
            ex_dest   <= id_enter ? id_dest : REG_ZERO;
            ex_wr     <= id_enter && id_reg_write;
            ex_ld     <= id_enter && id_mem_read;
            fwd_a_sel <= a_sel_nxt;
            fwd_b_sel <= b_sel_nxt;
            ex_bubble <= !id_enter;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (((a_sel_nxt != SEL_RF) || (b_sel_nxt != SEL_RF)) && (fwd_cnt != 16'hFFFF))
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end
`endif

endmodule
